// File: rtl/saturn_debug_pkg.sv
// Shared encodings for the Saturn debug-cycle controller: host command
// op codes, halt cause codes and the controller state encoding.
package saturn_debug_pkg;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_HALT     = 3'd1;
    localparam logic [2:0] OP_RUN      = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_SET_BP   = 3'd4;
    localparam logic [2:0] OP_CLR_BP   = 3'd5;
    localparam logic [2:0] OP_SET_CLIM = 3'd6;
    localparam logic [2:0] OP_CLR_CLIM = 3'd7;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_USER  = 3'd1;
    localparam logic [2:0] CAUSE_BP    = 3'd2;
    localparam logic [2:0] CAUSE_CLIM  = 3'd3;
    localparam logic [2:0] CAUSE_STEP  = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    // State the controller leaves reset in.
    function automatic state_t reset_state(input int halt_on_reset);
        return (halt_on_reset != 0) ? ST_HALTED : ST_RUN;
    endfunction

endpackage

// File: rtl/saturn_debug_ctrl_bp.sv
// Breakpoint unit: N_BP PC comparators with per-entry enable bits and a
// priority encoder reporting whether any enabled entry matches the current
// PC and the lowest matching index. Writes to an index >= N_BP match no
// entry and are therefore dropped.
module saturn_bp_unit #(
    parameter int N_BP   = 4,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_set,
    input  logic              i_clr,
    input  logic [3:0]        i_idx,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_hit,
    output logic [3:0]        o_idx
);

    logic [N_BP-1:0]   bp_en;
    logic [ADDR_W-1:0] bp_addr [N_BP];
    logic [N_BP-1:0]   bp_hit;

    // Enable bits are control state and follow reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bp_en <= '0;
        end else begin
            for (int k = 0; k < N_BP; k++) begin
                if (i_idx == 4'(k)) begin
                    if (i_set)
                        bp_en[k] <= 1'b1;
                    else if (i_clr)
                        bp_en[k] <= 1'b0;
                end
            end
        end
    end

    // Breakpoint addresses are plain data, only meaningful once enabled.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < N_BP; k++) begin
            if (i_set && (i_idx == 4'(k)))
                bp_addr[k] <= i_addr;
        end
    end

    // Per-entry compare and lowest-index-wins priority encode.
    always_comb begin
        o_idx = 4'd0;
        for (int k = 0; k < N_BP; k++)
            bp_hit[k] = bp_en[k] && (i_pc == bp_addr[k]);
        for (int k = N_BP - 1; k >= 0; k--) begin
            if (bp_hit[k])
                o_idx = 4'(k);
        end
        o_hit = |bp_hit;
    end

endmodule

// File: rtl/saturn_debug_ctrl.sv
// Saturn debug-cycle controller: evaluates breakpoints, a one-shot cycle
// limit, user halt and single-step, and at an instruction boundary emits a
// one-clock o_debug_cycle pulse and freezes the core until the host resumes.
module saturn_debug_ctrl
    import saturn_debug_pkg::*;
#(
    parameter int N_BP          = 4,
    parameter int ADDR_W        = 20,
    parameter int CTR_W         = 32,
    parameter int HALT_ON_RESET = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [3:0]        i_phases,
    input  logic [1:0]        i_phase,
    input  logic [CTR_W-1:0]  i_cycle_ctr,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_instr_done,
    input  logic              i_cmd_valid,
    input  logic [2:0]        i_cmd_op,
    input  logic [3:0]        i_cmd_idx,
    input  logic [CTR_W-1:0]  i_cmd_data,
    output logic              o_cmd_ready,
    output logic              o_debug_cycle,
    output logic              o_core_en,
    output logic              o_halted,
    output logic [2:0]        o_halt_cause,
    output logic [3:0]        o_bp_idx
);

    state_t           state, state_nxt;
    logic             halt_req, halt_req_nxt;
    logic             clim_en, clim_en_nxt;
    logic             skip_bp, skip_bp_nxt;
    logic [CTR_W-1:0] clim_val;
    logic             dbg_nxt;
    logic [2:0]       cause_nxt;
    logic [3:0]       bp_idx_nxt;

    logic             bnd;
    logic             cmd_fire;
    logic             cmd_halt;
    logic             bp_any;
    logic [3:0]       bp_hit_idx;
    logic             bp_fire;
    logic             clim_hit;
    logic             unused_inputs;

    // Phase index and the other strobes are informational only.
    assign unused_inputs = ^{i_phase, i_phases[2:0], i_cmd_data[CTR_W-1:ADDR_W]};

    assign bnd      = i_instr_done & i_phases[3];
    assign cmd_fire = i_cmd_valid & o_cmd_ready;
    assign cmd_halt = cmd_fire && (i_cmd_op == OP_HALT);
    assign clim_hit = clim_en && (i_cycle_ctr >= clim_val);
    assign bp_fire  = bp_any && !skip_bp;
    assign o_core_en = !o_halted;

    saturn_bp_unit #(
        .N_BP   (N_BP),
        .ADDR_W (ADDR_W)
    ) u_bp (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_set   (cmd_fire && (i_cmd_op == OP_SET_BP)),
        .i_clr   (cmd_fire && (i_cmd_op == OP_CLR_BP)),
        .i_idx   (i_cmd_idx),
        .i_addr  (i_cmd_data[ADDR_W-1:0]),
        .i_pc    (i_pc),
        .o_hit   (bp_any),
        .o_idx   (bp_hit_idx)
    );

    // Next-state, halt decision and cause selection.
    always_comb begin
        state_nxt    = state;
        halt_req_nxt = halt_req;
        clim_en_nxt  = clim_en;
        skip_bp_nxt  = skip_bp;
        dbg_nxt      = 1'b0;
        cause_nxt    = o_halt_cause;
        bp_idx_nxt   = o_bp_idx;

        if (cmd_fire && (i_cmd_op == OP_SET_CLIM))
            clim_en_nxt = 1'b1;
        else if (cmd_fire && (i_cmd_op == OP_CLR_CLIM))
            clim_en_nxt = 1'b0;

        case (state)
            ST_RUN: begin
                if (cmd_halt)
                    halt_req_nxt = 1'b1;
                if (bnd) begin
                    // The resume mask covers exactly one boundary.
                    skip_bp_nxt = 1'b0;
                    if (bp_fire || clim_hit || halt_req || cmd_halt) begin
                        state_nxt    = ST_HALTED;
                        dbg_nxt      = 1'b1;
                        halt_req_nxt = 1'b0;
                        if (clim_hit)
                            clim_en_nxt = 1'b0;
                        if (bp_fire) begin
                            cause_nxt  = CAUSE_BP;
                            bp_idx_nxt = bp_hit_idx;
                        end else if (clim_hit) begin
                            cause_nxt = CAUSE_CLIM;
                        end else begin
                            cause_nxt = CAUSE_USER;
                        end
                    end
                end
            end
            ST_HALTED: begin
                if (cmd_fire && (i_cmd_op == OP_RUN)) begin
                    state_nxt   = ST_RUN;
                    cause_nxt   = CAUSE_NONE;
                    skip_bp_nxt = (o_halt_cause == CAUSE_BP);
                end else if (cmd_fire && (i_cmd_op == OP_STEP)) begin
                    state_nxt   = ST_STEP;
                    skip_bp_nxt = (o_halt_cause == CAUSE_BP);
                end
            end
            ST_STEP: begin
                if (bnd) begin
                    state_nxt   = ST_HALTED;
                    dbg_nxt     = 1'b1;
                    cause_nxt   = CAUSE_STEP;
                    skip_bp_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_HALTED;
        endcase
    end

    // Control registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= reset_state(HALT_ON_RESET);
            halt_req      <= 1'b0;
            clim_en       <= 1'b0;
            skip_bp       <= 1'b0;
            o_debug_cycle <= 1'b0;
            o_halt_cause  <= CAUSE_NONE;
            o_bp_idx      <= 4'd0;
            o_cmd_ready   <= 1'b1;
            o_halted      <= (HALT_ON_RESET != 0);
        end else begin
            state         <= state_nxt;
            halt_req      <= halt_req_nxt;
            clim_en       <= clim_en_nxt;
            skip_bp       <= skip_bp_nxt;
            o_debug_cycle <= dbg_nxt;
            o_halt_cause  <= cause_nxt;
            o_bp_idx      <= bp_idx_nxt;
            o_cmd_ready   <= (state_nxt != ST_STEP);
            o_halted      <= (state_nxt == ST_HALTED);
        end
    end

    // Cycle limit value is data; only its enable is reset.
    always_ff @(posedge i_clk) begin
        if (cmd_fire && (i_cmd_op == OP_SET_CLIM))
            clim_val <= i_cmd_data;
    end

endmodule

// File: tb/tb_saturn_debug_ctrl.sv
// Directed bench for saturn_debug_ctrl: a table of one-clock vectors with
// hand-computed expected outputs, plus a reset-during-step sequence.
module tb_saturn_debug_ctrl;
    import saturn_debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  phases;
    logic [1:0]  phase;
    logic [31:0] ctr;
    logic [19:0] pc;
    logic        done;
    logic        cvalid;
    logic [2:0]  cop;
    logic [3:0]  cidx;
    logic [31:0] cdata;
    logic        ready, dbg, core_en, halted;
    logic [2:0]  cause;
    logic [3:0]  bpidx;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [3:0]  idx;
        logic [31:0] data;
        logic [19:0] pc;
        logic [31:0] ctr;
        logic        done;
        logic        ph3;
        logic        e_halt;
        logic        e_dbg;
        logic [2:0]  e_cause;
        logic [3:0]  e_bpi;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    saturn_debug_ctrl dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_phases     (phases),
        .i_phase      (phase),
        .i_cycle_ctr  (ctr),
        .i_pc         (pc),
        .i_instr_done (done),
        .i_cmd_valid  (cvalid),
        .i_cmd_op     (cop),
        .i_cmd_idx    (cidx),
        .i_cmd_data   (cdata),
        .o_cmd_ready  (ready),
        .o_debug_cycle(dbg),
        .o_core_en    (core_en),
        .o_halted     (halted),
        .o_halt_cause (cause),
        .o_bp_idx     (bpidx)
    );

    function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [3:0] idx,
                                input logic [31:0] data, input logic [19:0] p,
                                input logic [31:0] c, input logic d, input logic ph3,
                                input logic h, input logic db, input logic [2:0] ca,
                                input logic [3:0] bi, input logic r);
        vec_t t;
        t.v = v; t.op = op; t.idx = idx; t.data = data; t.pc = p; t.ctr = c;
        t.done = d; t.ph3 = ph3; t.e_halt = h; t.e_dbg = db; t.e_cause = ca;
        t.e_bpi = bi; t.e_rdy = r;
        return t;
    endfunction

    task automatic chk(input string name, input int vn, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, vn, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        cvalid = t.v; cop = t.op; cidx = t.idx; cdata = t.data;
        pc = t.pc; ctr = t.ctr; done = t.done;
        phases = {t.ph3, 3'b000};
        phase  = t.ph3 ? 2'd3 : 2'd0;
    endtask

    task automatic check_all(input int vn, input logic h, input logic db, input logic [2:0] ca,
                             input logic [3:0] bi, input logic r);
        chk("halted",   vn, 32'(halted),  32'(h));
        chk("core_en",  vn, 32'(core_en), 32'(!h));
        chk("dbg",      vn, 32'(dbg),     32'(db));
        chk("cause",    vn, 32'(cause),   32'(ca));
        chk("bp_idx",   vn, 32'(bpidx),   32'(bi));
        chk("ready",    vn, 32'(ready),   32'(r));
    endtask

    initial begin
        // v  op           idx   data        pc       ctr       dn    ph3   | halt dbg  cause       bpi   rdy
        vecs.push_back(mk(1'b1, OP_SET_BP,   4'd2, 32'h100, 20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 0
        vecs.push_back(mk(1'b1, OP_RUN,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 1
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h0FF, 32'd0,    1'b1, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 2
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h100, 32'd0,    1'b1, 1'b1, 1'b1, 1'b1, CAUSE_BP,   4'd2, 1'b1)); // 3 bp2 hit
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_BP,   4'd2, 1'b1)); // 4 pulse ends
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h100, 32'd0,    1'b1, 1'b1, 1'b1, 1'b0, CAUSE_BP,   4'd2, 1'b1)); // 5 bnd ignored
        vecs.push_back(mk(1'b1, OP_RUN,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 6
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h100, 32'd0,    1'b1, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 7 skipped
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h100, 32'd0,    1'b1, 1'b1, 1'b1, 1'b1, CAUSE_BP,   4'd2, 1'b1)); // 8 one-shot
        vecs.push_back(mk(1'b1, OP_CLR_BP,   4'd2, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_BP,   4'd2, 1'b1)); // 9
        vecs.push_back(mk(1'b1, OP_RUN,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 10
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h100, 32'd0,    1'b1, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 11 cleared bp
        vecs.push_back(mk(1'b1, OP_SET_CLIM, 4'd0, 32'd1000,20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 12
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h200, 32'd999,  1'b1, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 13
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h200, 32'd1000, 1'b1, 1'b1, 1'b1, 1'b1, CAUSE_CLIM, 4'd2, 1'b1)); // 14
        vecs.push_back(mk(1'b1, OP_RUN,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 15
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h200, 32'd1005, 1'b1, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 16 fired once
        vecs.push_back(mk(1'b1, OP_HALT,     4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 17 pending
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h200, 32'd0,    1'b1, 1'b1, 1'b1, 1'b1, CAUSE_USER, 4'd2, 1'b1)); // 18
        vecs.push_back(mk(1'b1, OP_STEP,     4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_USER, 4'd2, 1'b0)); // 19
        vecs.push_back(mk(1'b1, OP_RUN,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_USER, 4'd2, 1'b0)); // 20 not accepted
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h000, 32'd0,    1'b1, 1'b0, 1'b0, 1'b0, CAUSE_USER, 4'd2, 1'b0)); // 21 unqualified
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h000, 32'd0,    1'b1, 1'b1, 1'b1, 1'b1, CAUSE_STEP, 4'd2, 1'b1)); // 22
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_STEP, 4'd2, 1'b1)); // 23
        vecs.push_back(mk(1'b1, OP_SET_BP,   4'd0, 32'h300, 20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_STEP, 4'd2, 1'b1)); // 24
        vecs.push_back(mk(1'b1, OP_SET_BP,   4'd3, 32'h300, 20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_STEP, 4'd2, 1'b1)); // 25
        vecs.push_back(mk(1'b1, OP_SET_CLIM, 4'd0, 32'd50,  20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_STEP, 4'd2, 1'b1)); // 26
        vecs.push_back(mk(1'b1, OP_RUN,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd2, 1'b1)); // 27
        vecs.push_back(mk(1'b1, OP_HALT,     4'd0, 32'h0,   20'h300, 32'd60,   1'b1, 1'b1, 1'b1, 1'b1, CAUSE_BP,   4'd0, 1'b1)); // 28 all at once
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_BP,   4'd0, 1'b1)); // 29
        vecs.push_back(mk(1'b1, OP_SET_BP,   4'd7, 32'h400, 20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_BP,   4'd0, 1'b1)); // 30 idx out of range
        vecs.push_back(mk(1'b1, OP_RUN,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 31
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h500, 32'd0,    1'b1, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 32
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h400, 32'd0,    1'b1, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 33
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h300, 32'd70,   1'b1, 1'b1, 1'b1, 1'b1, CAUSE_BP,   4'd0, 1'b1)); // 34
        vecs.push_back(mk(1'b1, OP_RUN,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 35
        vecs.push_back(mk(1'b1, OP_HALT,     4'd0, 32'h0,   20'h123, 32'd0,    1'b1, 1'b1, 1'b1, 1'b1, CAUSE_USER, 4'd0, 1'b1)); // 36 HALT at bnd
        vecs.push_back(mk(1'b1, OP_SET_CLIM, 4'd0, 32'd10,  20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_USER, 4'd0, 1'b1)); // 37
        vecs.push_back(mk(1'b1, OP_CLR_CLIM, 4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b1, 1'b0, CAUSE_USER, 4'd0, 1'b1)); // 38
        vecs.push_back(mk(1'b1, OP_RUN,      4'd0, 32'h0,   20'h000, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 39
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h777, 32'd20,   1'b1, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 40
        vecs.push_back(mk(1'b1, OP_SET_BP,   4'd1, 32'h777, 20'h777, 32'd0,    1'b1, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1)); // 41 old bp used
        vecs.push_back(mk(1'b0, OP_NOP,      4'd0, 32'h0,   20'h777, 32'd0,    1'b1, 1'b1, 1'b1, 1'b1, CAUSE_BP,   4'd1, 1'b1)); // 42

        // Reset sequence
        rst = 1'b1;
        drive(mk(1'b0, OP_NOP, 4'd0, 32'h0, 20'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all(-1, 1'b1, 1'b0, CAUSE_NONE, 4'd0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_all(i, vecs[i].e_halt, vecs[i].e_dbg, vecs[i].e_cause, vecs[i].e_bpi, vecs[i].e_rdy);
        end

        // Reset while stepping: everything returns to reset values, bps disabled.
        drive(mk(1'b1, OP_STEP, 4'd0, 32'h0, 20'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0));
        @(posedge clk); #1;
        check_all(100, 1'b0, 1'b0, CAUSE_BP, 4'd1, 1'b0);
        drive(mk(1'b0, OP_NOP, 4'd0, 32'h0, 20'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all(101, 1'b1, 1'b0, CAUSE_NONE, 4'd0, 1'b1);
        drive(mk(1'b1, OP_RUN, 4'd0, 32'h0, 20'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0));
        @(posedge clk); #1;
        check_all(102, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1);
        drive(mk(1'b0, OP_NOP, 4'd0, 32'h0, 20'h777, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0));
        @(posedge clk); #1;
        check_all(103, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1);
        drive(mk(1'b0, OP_NOP, 4'd0, 32'h0, 20'h300, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0));
        @(posedge clk); #1;
        check_all(104, 1'b0, 1'b0, CAUSE_NONE, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
